// File: rtl/status_cond_unit.sv
// Status register {N,Z,C,V} and ARM condition-code evaluation for the ID stage.
// Optional macro STATUS_FWD_EN: forward EXE flags to ID instead of requesting a stall.
module status_cond_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  logic       s_we,
    input  logic [3:0] s_b,
    input  logic       id_valid,
    input  logic [3:0] cond,
    output logic [3:0] sr,
    output logic       carry,
    output logic       cond_ok,
    output logic       flag_hazard
);

    localparam logic [3:0] COND_AL = 4'b1110;

    logic [3:0] eff_flags;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       pass;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= 4'b0000;
        end else if (s_we && !freeze) begin
            sr <= s_b;
        end
    end

    assign carry = sr[1];

`ifdef STATUS_FWD_EN
    // EXE flags are presented even under freeze: the producer is re-issued next cycle.
    assign eff_flags   = s_we ? s_b : sr;
    assign flag_hazard = 1'b0;
`else
    assign eff_flags   = sr;
    assign flag_hazard = s_we & id_valid & (cond != COND_AL);
`endif

    assign flag_n = eff_flags[3];
    assign flag_z = eff_flags[2];
    assign flag_c = eff_flags[1];
    assign flag_v = eff_flags[0];

    always_comb begin
        pass = 1'b0;
        case (cond)
            4'b0000: pass = flag_z;
            4'b0001: pass = ~flag_z;
            4'b0010: pass = flag_c;
            4'b0011: pass = ~flag_c;
            4'b0100: pass = flag_n;
            4'b0101: pass = ~flag_n;
            4'b0110: pass = flag_v;
            4'b0111: pass = ~flag_v;
            4'b1000: pass = flag_c & ~flag_z;
            4'b1001: pass = ~flag_c | flag_z;
            4'b1010: pass = (flag_n == flag_v);
            4'b1011: pass = (flag_n != flag_v);
            4'b1100: pass = ~flag_z & (flag_n == flag_v);
            4'b1101: pass = flag_z | (flag_n != flag_v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    assign cond_ok = id_valid & pass;

endmodule
